// File: rtl/iq_issue_ctrl.sv
// Instruction queue and issue scheduler: buffers fetched instructions and dispatches the head to RS or LSB.
// Optional feature macro IQ_BYPASS_EN: an empty queue lets a legal, unblocked fetch issue at its push edge.
module iq_issue_ctrl #(
   parameter int IQ_DEPTH_LOG = 3,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   flush_in,
   input  logic                   if_valid_in,
   input  logic [31:0]            if_inst_in,
   input  logic [31:0]            if_pc_in,
   output logic                   iq_full_out,
   output logic [31:0]            dec_inst_out,
   input  logic [5:0]             dec_order_in,
   input  logic                   rs_full_in,
   input  logic                   lsb_full_in,
   input  logic                   rob_full_in,
   output logic                   issue_valid_out,
   output logic                   issue_to_lsb_out,
   output logic [31:0]            issue_inst_out,
   output logic [31:0]            issue_pc_out,
   output logic [5:0]             issue_order_out,
   output logic [STALL_CNT_W-1:0] stall_cnt_out
);

   localparam int DEPTH = 1 << IQ_DEPTH_LOG;
   localparam logic [IQ_DEPTH_LOG:0] DEPTH_C = {1'b1, {IQ_DEPTH_LOG{1'b0}}};

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
   typedef enum logic [1:0] {TGT_NONE, TGT_RS, TGT_LSB} tgt_t;

   function automatic tgt_t classify(input logic [6:0] opcode);
      tgt_t t;
      case (opcode)
         7'h03, 7'h23:                                   t = TGT_LSB;
         7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33: t = TGT_RS;
         default:                                        t = TGT_NONE;
      endcase
      return t;
   endfunction

   function automatic logic target_blocked(input tgt_t t, input logic rob_full,
                                           input logic rs_full, input logic lsb_full);
      return rob_full | ((t == TGT_LSB) ? lsb_full : rs_full);
   endfunction

   logic [31:0]             mem_inst [DEPTH];
   logic [31:0]             mem_pc   [DEPTH];
   logic [IQ_DEPTH_LOG-1:0] head, tail;
   logic [IQ_DEPTH_LOG:0]   count, count_next;
   state_t                  state, state_next;

   logic        head_valid;
   logic [31:0] head_inst, head_pc;
   tgt_t        head_tgt;
   logic        head_blocked, head_issue, head_discard, head_stall;
   logic        bypass, push, pop, issue;
   logic [31:0] sel_inst, sel_pc;
   logic        sel_lsb;

   assign head_valid   = (count != '0);
   assign head_inst    = mem_inst[head];
   assign head_pc      = mem_pc[head];
   assign head_tgt     = classify(head_inst[6:0]);
   assign head_blocked = target_blocked(head_tgt, rob_full_in, rs_full_in, lsb_full_in);
   assign head_issue   = head_valid && (head_tgt != TGT_NONE) && !head_blocked;
   // An illegal head is dropped in one cycle; it neither issues nor stalls.
   assign head_discard = head_valid && (head_tgt == TGT_NONE);
   assign head_stall   = head_valid && (head_tgt != TGT_NONE) && head_blocked;
   assign pop          = head_issue | head_discard;

`ifdef IQ_BYPASS_EN
   tgt_t byp_tgt;
   assign byp_tgt      = classify(if_inst_in[6:0]);
   assign bypass       = !head_valid && if_valid_in && (byp_tgt != TGT_NONE) &&
                         !target_blocked(byp_tgt, rob_full_in, rs_full_in, lsb_full_in);
   assign dec_inst_out = head_valid ? head_inst : (if_valid_in ? if_inst_in : '0);
`else
   assign bypass       = 1'b0;
   assign dec_inst_out = head_valid ? head_inst : '0;
`endif

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign push  = if_valid_in && !bypass && ((count < DEPTH_C) || pop);
   assign issue = head_issue | bypass;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_inst = head_inst;
      sel_pc   = head_pc;
      sel_lsb  = (head_tgt == TGT_LSB);
`ifdef IQ_BYPASS_EN
      if (bypass) begin
         sel_inst = if_inst_in;
         sel_pc   = if_pc_in;
         sel_lsb  = (byp_tgt == TGT_LSB);
      end
`endif
   end

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + (IQ_DEPTH_LOG + 1)'(1);
         2'b01:   count_next = count - (IQ_DEPTH_LOG + 1)'(1);
         default: count_next = count;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (head_stall) state_next = STALL;
         STALL:   if (!head_stall) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         state            <= RUN;
         iq_full_out      <= 1'b0;
         issue_valid_out  <= 1'b0;
         issue_to_lsb_out <= 1'b0;
         issue_inst_out   <= '0;
         issue_pc_out     <= '0;
         issue_order_out  <= '0;
         stall_cnt_out    <= '0;
      end else if (flush_in) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         state           <= RUN;
         iq_full_out     <= 1'b0;
         issue_valid_out <= 1'b0;
      end else if (!rdy_in) begin
         issue_valid_out <= 1'b0;
      end else begin
         if (pop)  head <= head + IQ_DEPTH_LOG'(1);
         if (push) tail <= tail + IQ_DEPTH_LOG'(1);
         count           <= count_next;
         iq_full_out     <= (count_next == DEPTH_C);
         state           <= state_next;
         if (state_next == STALL && stall_cnt_out != '1)
            stall_cnt_out <= stall_cnt_out + STALL_CNT_W'(1);
         issue_valid_out <= issue;
         if (issue) begin
            issue_to_lsb_out <= sel_lsb;
            issue_inst_out   <= sel_inst;
            issue_pc_out     <= sel_pc;
            issue_order_out  <= dec_order_in;
         end
      end
   end

   // NOTE: the storage array has no reset; an entry is only read once count marks it valid.
   always_ff @(posedge clk_in) begin
      if (!rst_in && !flush_in && rdy_in && push) begin
         mem_inst[tail] <= if_inst_in;
         mem_pc[tail]   <= if_pc_in;
      end
   end

endmodule

// File: doc/iq_issue_ctrl.md
# iq_issue_ctrl

Instruction queue and issue scheduler between instruction fetch and the out-of-order back end. Buffers fetched instructions, presents the queue head to the combinational decoder, and dispatches the head with its decoded order either to the reservation station (RS) or to the load/store buffer (LSB). Throttles issue on back-end back-pressure, discards on flush, and counts stall cycles for performance monitoring.

## Interface
- `IQ_DEPTH_LOG`, default 3: log2 of queue depth; depth = 2^IQ_DEPTH_LOG = 8 entries.
- `STALL_CNT_W`, default 16: width of the stall counter.

Ports:
- `clk_in` in 1: the single clock; everything is rising-edge.
- `rst_in` in 1: reset, synchronous and active-high.
- `rdy_in` in 1: global pause; low means hold state.
- `flush_in` in 1: branch mispredict; discard all queued work.
- `if_valid_in` in 1: fetch offers an instruction.
- `if_inst_in` in 32: the instruction word.
- `if_pc_in` in 32: PC of the instruction.
- `iq_full_out` out 1: queue full (registered); fetch must not offer while high.
- `dec_inst_out` out 32: head instruction to the decoder; 0 when the queue is empty.
- `dec_order_in` in 6: decoder order code for `dec_inst_out`, same cycle.
- `rs_full_in` in 1: RS full.
- `lsb_full_in` in 1: LSB full.
- `rob_full_in` in 1: ROB full.
- `issue_valid_out` out 1: one-cycle issue pulse.
- `issue_to_lsb_out` out 1: 1 = LSB target, 0 = RS target.
- `issue_inst_out` out 32: issued instruction word.
- `issue_pc_out` out 32: issued PC.
- `issue_order_out` out 6: issued order code.
- `stall_cnt_out` out STALL_CNT_W: saturating count of cycles spent in STALL.

## Operation
- Circular buffer with head pointer, tail pointer and count (IQ_DEPTH_LOG+1 bits). Pointers wrap modulo depth.
- **Push:** accepted when `if_valid_in` is high and count < depth. A push while full is dropped silently.
- **Pop:** the head pops on an issue or a discard. Push and pop in the same cycle leave count unchanged. This is legal when full: the pop frees the slot the push uses, judged on pre-edge count.
- **Classification** uses head opcode inst[6:0]:
  - 0x03 and 0x23 go to the LSB.
  - 0x37, 0x17, 0x6f, 0x67, 0x63, 0x13 and 0x33 go to the RS.
  - Any other opcode is illegal. It is popped without issue (discard, one cycle) and counts as neither issue nor stall.
- **Issue condition:** head valid, legal opcode, `rob_full_in`=0, and the selected target's full flag is 0. On issue:
  - The outputs register the head fields and `dec_order_in`.
  - `issue_valid_out`=1 for exactly one cycle.
- **FSM:**
  - RUN: issuing or idle. Goes to STALL when the head is valid and legal but blocked.
  - STALL: `stall_cnt_out` increments each cycle, saturating at all-ones. Returns to RUN in the cycle the head issues, or on flush.
- **Priority:** `rst_in` > `flush_in` > `rdy_in` low > normal.
  - Flush empties the queue, ignores a simultaneous push, suppresses issue, and forces RUN. Flush is honored even while `rdy_in`=0.
  - `rdy_in`=0: no push, pop, FSM or counter change. `issue_valid_out` is cleared at the edge.
- **Reset values:** pointers and count 0, FSM RUN, `iq_full_out`=0, `issue_valid_out`=0, `issue_to_lsb_out`=0, `issue_inst_out`/`issue_pc_out`/`issue_order_out`=0, `stall_cnt_out`=0. Reset mid-stall drops all entries.

## Timing
- Push at edge N makes the entry head-visible in cycle N+1.
- If unblocked, `issue_valid_out` is high in cycle N+2.
- Sustained throughput: one issue per cycle.
- `iq_full_out` reflects post-edge count; it is high in the cycle after the 8th outstanding push.
- `dec_inst_out` is combinational from head storage. `dec_order_in` is sampled at the issuing edge only.
- Flush at edge F: `issue_valid_out`=0 and count=0 in cycle F+1.

## Configuration
- `IQ_BYPASS_EN` defined:
  - When count=0 and no flush, an incoming legal, unblocked instruction issues at the push edge itself, so `issue_valid_out` rises in cycle N+1.
  - The instruction never occupies a slot.
  - The decoder sees `if_inst_in` via `dec_inst_out` in that cycle.
- `IQ_BYPASS_EN` undefined: all instructions pass through the queue, with minimum latency 2.

## Test plan
- **Straight-line issue:** push ADDI 0x00500093, pc 0x0, then LW 0x0000a103, pc 0x4, all full flags 0. Expect:
  - Two consecutive pulses: first `issue_to_lsb_out`=0, `issue_pc_out`=0x0; second `issue_to_lsb_out`=1, `issue_pc_out`=0x4.
  - Cycles N+2 and N+3 without bypass; N+1 and N+2 with `IQ_BYPASS_EN`.
- **Fill and wrap:** hold `rob_full_in`=1 and push 9 instructions. Expect `iq_full_out`=1 after the 8th, 9th dropped. Release ROB, push 4 more during drain. Expect 12 issues, in order, with correct PCs across the pointer wrap.
- **Targeted back-pressure:** head SW, `lsb_full_in`=1 for 5 cycles, `rs_full_in`=0. Expect:
  - No issue, FSM in STALL, `stall_cnt_out`=5.
  - SW issues with `issue_to_lsb_out`=1 the cycle after release.
- **Flush:** 3 queued, then flush together with a push. Expect count 0, no `issue_valid_out` afterward, and the pushed instruction absent.
- **Illegal opcode and pause:**
  - Head 0x0000007f: popped in one cycle, never issued, `stall_cnt_out` unchanged.
  - `rdy_in`=0 for 4 cycles with a valid head: no issue, count frozen, `stall_cnt_out` frozen.
- **Reset mid-stall:** `rst_in` pulse while in STALL with count 5. Expect all outputs at their reset values next cycle.
